// File: rtl/alu_exec_stage.sv
// Two-stage registered execute pipeline around an external combinational ALU.
// Tracks the architectural flag register and resolves a branch condition per op.
module alu_exec_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_ctrl,
    input  logic [31:0]       in_x,
    input  logic [31:0]       in_y,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_setflags,
    input  logic [2:0]        in_cond,
    input  logic              flush,
    output logic [3:0]        alu_ctrl,
    output logic [31:0]       alu_x,
    output logic [31:0]       alu_y,
    input  logic [31:0]       alu_result,
    input  logic              alu_v,
    input  logic              alu_z,
    input  logic              alu_s,
    input  logic              alu_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_cond_pass,
    output logic              out_illegal,
    output logic [3:0]        flags_q
);

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned COND_W = 3;
    localparam int unsigned FLAG_W = 4;

    logic               op_valid;
    logic [TAG_W-1:0]   op_tag;
    logic               op_setflags;
    logic [COND_W-1:0]  op_cond;

    logic               adv;
    logic               accept;
    logic               xfer;
    logic               legal;
    logic               flag_wr;
    logic [FLAG_W-1:0]  alu_flags;
    logic [FLAG_W-1:0]  eff_flags;
    logic               cond_pass;

    // Flags are packed {V,Z,S,C}
    function automatic logic cond_eval(input logic [COND_W-1:0] c, input logic [FLAG_W-1:0] f);
        logic v, z, s, cy;
        logic r;
        {v, z, s, cy} = f;
        case (c)
            3'd0:    r = 1'b1;
            3'd1:    r = z;
            3'd2:    r = ~z;
            3'd3:    r = s ^ v;
            3'd4:    r = ~(s ^ v);
            3'd5:    r = cy;
            3'd6:    r = ~cy;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Handshake and transfer qualifiers
    always_comb begin
        adv       = ~out_valid | out_ready;
        in_ready  = (~op_valid | adv) & ~flush;
        accept    = in_valid & in_ready;
        xfer      = op_valid & adv & ~flush;
        legal     = (alu_ctrl >= CTRL_W'(1)) && (alu_ctrl <= CTRL_W'(10));
        flag_wr   = op_setflags & legal;
        alu_flags = {alu_v, alu_z, alu_s, alu_c};
        eff_flags = flag_wr ? alu_flags : flags_q;
        cond_pass = cond_eval(op_cond, eff_flags);
    end

    // OP stage: operand register feeding the ALU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid    <= 1'b0;
            alu_ctrl    <= '0;
            alu_x       <= '0;
            alu_y       <= '0;
            op_tag      <= '0;
            op_setflags <= 1'b0;
            op_cond     <= '0;
        end else if (flush) begin
            op_valid <= 1'b0;
        end else if (accept) begin
            op_valid    <= 1'b1;
            alu_ctrl    <= in_ctrl;
            alu_x       <= in_x;
            alu_y       <= in_y;
            op_tag      <= in_tag;
            op_setflags <= in_setflags;
            op_cond     <= in_cond;
        end else if (adv) begin
            op_valid <= 1'b0;
        end
    end

    // WB stage: result register plus architectural flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_tag       <= '0;
            out_cond_pass <= 1'b0;
            out_illegal   <= 1'b0;
            flags_q       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= op_valid;
            if (xfer) begin
                out_result    <= legal ? alu_result : 32'd0;
                out_tag       <= op_tag;
                out_cond_pass <= cond_pass;
                out_illegal   <= ~legal;
                if (flag_wr) begin
                    flags_q <= alu_flags;
                end
            end
        end
    end

endmodule
